// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: control bundle between the sequencer and the multi-cycle datapath/memory
interface multicycle_control_fsm_if #(
    parameter int INSTR_WIDTH = 32
);
    logic [INSTR_WIDTH-1:0] instr_i;
    logic                   zero_i;
    logic                   mem_ready_i;
    logic                   mem_req_o;
    logic                   MemWrite_o;
    logic                   AdrSrc_o;
    logic                   IRWrite_o;
    logic                   PCWrite_o;
    logic                   RegWrite_o;
    logic [1:0]             ResultSrc_o;
    logic [1:0]             ALUSrcA_o;
    logic [1:0]             ALUSrcB_o;
    logic [2:0]             ALUControl_o;
    logic [1:0]             ImmSrc_o;
    logic                   instr_done_o;
    logic                   illegal_o;

    modport master (
        input  instr_i, zero_i, mem_ready_i,
        output mem_req_o, MemWrite_o, AdrSrc_o, IRWrite_o, PCWrite_o, RegWrite_o,
               ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ALUControl_o, ImmSrc_o,
               instr_done_o, illegal_o
    );

    modport slave (
        output instr_i, zero_i, mem_ready_i,
        input  mem_req_o, MemWrite_o, AdrSrc_o, IRWrite_o, PCWrite_o, RegWrite_o,
               ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ALUControl_o, ImmSrc_o,
               instr_done_o, illegal_o
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Fetch/Decode/Execute/Memory/Writeback sequencer for a multi-cycle RV32I core
module multicycle_control_fsm #(
    parameter int INSTR_WIDTH = 32
) (
    input logic                    clk,
    input logic                    rst,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       unused_bits;
    logic       mem_ready, zero;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, done, illegal;
    logic [1:0] result_src, src_a, src_b, alu_op, imm_src;
    logic [2:0] alu_ctrl;

    assign opcode      = bus.instr_i[6:0];
    assign funct3      = bus.instr_i[14:12];
    assign funct7_5    = bus.instr_i[30];
    assign unused_bits = ^{bus.instr_i[INSTR_WIDTH-1:31], bus.instr_i[29:15], bus.instr_i[11:7]};
    assign mem_ready   = bus.mem_ready_i;
    assign zero        = bus.zero_i;

    // State register; reset aborts any in-flight instruction back to FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Next state and per-state controls; enables are held off while reset is asserted
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;
        result_src = 2'b00;
        src_a      = 2'b00;
        src_b      = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            FETCH: begin
                mem_req    = 1'b1;
                src_b      = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                state_d    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                src_a = 2'b01;
                src_b = 2'b01;
                case (opcode)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011:             state_d = EXECR;
                    7'b0010011:             state_d = EXECI;
                    7'b1100011:             state_d = BEQ;
                    7'b1101111:             state_d = JAL;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                        done    = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                state_d = opcode[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                state_d = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                done       = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                done      = mem_ready;
                state_d   = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                src_a   = 2'b10;
                alu_op  = 2'b10;
                state_d = ALUWB;
            end
            EXECI: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_op  = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                done      = 1'b1;
                state_d   = FETCH;
            end
            BEQ: begin
                src_a    = 2'b10;
                alu_op   = 2'b01;
                pc_write = zero;
                done     = 1'b1;
                state_d  = FETCH;
            end
            JAL: begin
                src_a     = 2'b01;
                src_b     = 2'b10;
                pc_write  = 1'b1;
                reg_write = 1'b1;
                done      = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (rst) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            done      = 1'b0;
            illegal   = 1'b0;
        end
    end

    // ALU operation: fixed add/sub, or decoded from funct3/funct7 (sub only for R-type)
    always_comb begin
        alu_ctrl = 3'b000;
        if (alu_op == 2'b01) alu_ctrl = 3'b001;
        else if (alu_op == 2'b10)
            alu_ctrl = (funct3 == 3'b000) ? ((opcode[5] & funct7_5) ? 3'b001 : 3'b000) :
                       (funct3 == 3'b010) ? 3'b101 :
                       (funct3 == 3'b110) ? 3'b011 :
                       (funct3 == 3'b111) ? 3'b010 : 3'b000;
    end

    // Immediate format straight from the opcode
    always_comb begin
        imm_src = (opcode == 7'b0100011) ? 2'b01 :
                  (opcode == 7'b1100011) ? 2'b10 :
                  (opcode == 7'b1101111) ? 2'b11 : 2'b00;
    end

    assign bus.mem_req_o    = mem_req;
    assign bus.MemWrite_o   = mem_write;
    assign bus.AdrSrc_o     = adr_src;
    assign bus.IRWrite_o    = ir_write;
    assign bus.PCWrite_o    = pc_write;
    assign bus.RegWrite_o   = reg_write;
    assign bus.ResultSrc_o  = result_src;
    assign bus.ALUSrcA_o    = src_a;
    assign bus.ALUSrcB_o    = src_b;
    assign bus.ALUControl_o = alu_ctrl;
    assign bus.ImmSrc_o     = imm_src;
    assign bus.instr_done_o = done;
    assign bus.illegal_o    = illegal;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed per-cycle checks of enables, selects and latency
module tb_multicycle_control_fsm;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    multicycle_control_fsm_if #(.INSTR_WIDTH(32)) bus ();
    multicycle_control_fsm #(.INSTR_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    // {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, instr_done, illegal}
    logic [6:0] en;
    // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
    logic [9:0] sel;
    assign en  = {bus.mem_req_o, bus.MemWrite_o, bus.IRWrite_o, bus.PCWrite_o,
                  bus.RegWrite_o, bus.instr_done_o, bus.illegal_o};
    assign sel = {bus.AdrSrc_o, bus.ResultSrc_o, bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALUControl_o};

    localparam logic [9:0] S_FETCH   = {1'b0, 2'b10, 2'b00, 2'b10, 3'b000};
    localparam logic [9:0] S_DECODE  = {1'b0, 2'b00, 2'b01, 2'b01, 3'b000};
    localparam logic [9:0] S_MEMADR  = {1'b0, 2'b00, 2'b10, 2'b01, 3'b000};
    localparam logic [9:0] S_MEMACC  = {1'b1, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [9:0] S_MEMWB   = {1'b0, 2'b01, 2'b00, 2'b00, 3'b000};
    localparam logic [9:0] S_ALUWB   = {1'b0, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [9:0] S_EXADD   = {1'b0, 2'b00, 2'b10, 2'b00, 3'b000};
    localparam logic [9:0] S_EXSUB   = {1'b0, 2'b00, 2'b10, 2'b00, 3'b001};
    localparam logic [9:0] S_BEQ     = {1'b0, 2'b00, 2'b10, 2'b00, 3'b001};
    localparam logic [9:0] S_JAL     = {1'b0, 2'b00, 2'b01, 2'b10, 3'b000};
    localparam logic [9:0] M_FULL    = 10'b1_11_11_11_111;
    localparam logic [9:0] M_DP      = 10'b0_00_11_11_111;
    localparam logic [9:0] M_BR      = 10'b0_11_11_11_111;
    localparam logic [9:0] M_ADR     = 10'b1_00_00_00_000;
    localparam logic [9:0] M_RS      = 10'b0_11_00_00_000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 2;
        if (en !== 7'b0) begin n_bad++; $display("FAIL reset enables: got %b want %b", en, 7'b0); end
        if (sel !== S_FETCH) begin n_bad++; $display("FAIL reset selects: got %b want %b", sel, S_FETCH); end
        rst = 1'b0;
        #1;
        n_cmp += 1;
        if (en !== 7'b1011000) begin n_bad++; $display("FAIL reset_release enables: got %b want %b", en, 7'b1011000); end
    endtask

    task automatic test_reset_mid_exec();
        bus.instr_i = 32'h002081B3;
        bus.mem_ready_i = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        n_cmp += 2;
        if (en !== 7'b0) begin n_bad++; $display("FAIL mid_execr enables: got %b want %b", en, 7'b0); end
        if (sel !== S_EXADD) begin n_bad++; $display("FAIL mid_execr selects: got %b want %b", sel, S_EXADD); end
        rst = 1'b1;
        #1;
        n_cmp += 2;
        if (en !== 7'b0) begin n_bad++; $display("FAIL mid_rst enables: got %b want %b", en, 7'b0); end
        if (sel !== S_FETCH) begin n_bad++; $display("FAIL mid_rst selects: got %b want %b", sel, S_FETCH); end
        @(posedge clk); #1;
        n_cmp += 1;
        if (en !== 7'b0) begin n_bad++; $display("FAIL mid_rst_hold enables: got %b want %b", en, 7'b0); end
        rst = 1'b0;
        #1;
        n_cmp += 2;
        if (en !== 7'b1011000) begin n_bad++; $display("FAIL mid_release enables: got %b want %b", en, 7'b1011000); end
        if (sel !== S_FETCH) begin n_bad++; $display("FAIL mid_release selects: got %b want %b", sel, S_FETCH); end
    endtask

    task automatic test_lw();
        logic [6:0] ee [5];
        logic [9:0] es [5];
        logic [9:0] em [5];
        ee = '{7'b1011000, 7'b0, 7'b0, 7'b1000000, 7'b0000110};
        es = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMACC, S_MEMWB};
        em = '{M_FULL, M_DP, M_DP, M_ADR, M_RS};
        bus.instr_i = 32'h00802283;
        bus.mem_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp += 3;
            if (en !== ee[i]) begin n_bad++; $display("FAIL lw c%0d enables: got %b want %b", i, en, ee[i]); end
            if ((sel & em[i]) !== (es[i] & em[i])) begin n_bad++; $display("FAIL lw c%0d selects: got %b want %b mask %b", i, sel, es[i], em[i]); end
            if (bus.ImmSrc_o !== 2'b00) begin n_bad++; $display("FAIL lw c%0d ImmSrc: got %b want 00", i, bus.ImmSrc_o); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_add_sub();
        logic [6:0] ee [4];
        logic [9:0] es [4];
        logic [9:0] em [4];
        ee = '{7'b1011000, 7'b0, 7'b0, 7'b0000110};
        em = '{M_FULL, M_DP, M_DP, M_RS};
        bus.mem_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.instr_i = (k == 0) ? 32'h002081B3 : 32'h402081B3;
            es = '{S_FETCH, S_DECODE, (k == 0) ? S_EXADD : S_EXSUB, S_ALUWB};
            for (int i = 0; i < 4; i++) begin
                #1;
                n_cmp += 3;
                if (en !== ee[i]) begin n_bad++; $display("FAIL rtype%0d c%0d enables: got %b want %b", k, i, en, ee[i]); end
                if ((sel & em[i]) !== (es[i] & em[i])) begin n_bad++; $display("FAIL rtype%0d c%0d selects: got %b want %b mask %b", k, i, sel, es[i], em[i]); end
                if (bus.ImmSrc_o !== 2'b00) begin n_bad++; $display("FAIL rtype%0d c%0d ImmSrc: got %b want 00", k, i, bus.ImmSrc_o); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_beq();
        logic [6:0] ee [3];
        logic [9:0] es [3];
        logic [9:0] em [3];
        logic       rd2 [4];
        logic [6:0] ee2 [4];
        logic [9:0] es2 [4];
        logic [9:0] em2 [4];
        ee  = '{7'b1011000, 7'b0, 7'b0001010};
        es  = '{S_FETCH, S_DECODE, S_BEQ};
        em  = '{M_FULL, M_DP, M_BR};
        rd2 = '{1'b0, 1'b1, 1'b1, 1'b1};
        ee2 = '{7'b1000000, 7'b1011000, 7'b0, 7'b0000010};
        es2 = '{S_FETCH, S_FETCH, S_DECODE, S_BEQ};
        em2 = '{M_FULL, M_FULL, M_DP, M_BR};
        bus.instr_i = 32'h00000463;
        bus.mem_ready_i = 1'b1;
        bus.zero_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp += 3;
            if (en !== ee[i]) begin n_bad++; $display("FAIL beq_taken c%0d enables: got %b want %b", i, en, ee[i]); end
            if ((sel & em[i]) !== (es[i] & em[i])) begin n_bad++; $display("FAIL beq_taken c%0d selects: got %b want %b mask %b", i, sel, es[i], em[i]); end
            if (bus.ImmSrc_o !== 2'b10) begin n_bad++; $display("FAIL beq_taken c%0d ImmSrc: got %b want 10", i, bus.ImmSrc_o); end
            @(posedge clk); #1;
        end
        bus.zero_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready_i = rd2[i];
            #1;
            n_cmp += 3;
            if (en !== ee2[i]) begin n_bad++; $display("FAIL beq_nottaken c%0d enables: got %b want %b", i, en, ee2[i]); end
            if ((sel & em2[i]) !== (es2[i] & em2[i])) begin n_bad++; $display("FAIL beq_nottaken c%0d selects: got %b want %b mask %b", i, sel, es2[i], em2[i]); end
            if (bus.ImmSrc_o !== 2'b10) begin n_bad++; $display("FAIL beq_nottaken c%0d ImmSrc: got %b want 10", i, bus.ImmSrc_o); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_wait();
        logic       rd [7];
        logic [6:0] ee [7];
        logic [9:0] es [7];
        logic [9:0] em [7];
        rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        ee = '{7'b1011000, 7'b0, 7'b0, 7'b1100000, 7'b1100000, 7'b1100000, 7'b1100010};
        es = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMACC, S_MEMACC, S_MEMACC, S_MEMACC};
        em = '{M_FULL, M_DP, M_DP, M_ADR, M_ADR, M_ADR, M_ADR};
        bus.instr_i = 32'h00502223;
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready_i = rd[i];
            #1;
            n_cmp += 3;
            if (en !== ee[i]) begin n_bad++; $display("FAIL sw c%0d enables: got %b want %b", i, en, ee[i]); end
            if ((sel & em[i]) !== (es[i] & em[i])) begin n_bad++; $display("FAIL sw c%0d selects: got %b want %b mask %b", i, sel, es[i], em[i]); end
            if (bus.ImmSrc_o !== 2'b01) begin n_bad++; $display("FAIL sw c%0d ImmSrc: got %b want 01", i, bus.ImmSrc_o); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jal_illegal();
        logic [6:0] ee [3];
        logic [9:0] es [3];
        logic [9:0] em [3];
        logic [6:0] ee2 [3];
        ee  = '{7'b1011000, 7'b0, 7'b0001110};
        es  = '{S_FETCH, S_DECODE, S_JAL};
        em  = '{M_FULL, M_DP, M_BR};
        ee2 = '{7'b1011000, 7'b0000011, 7'b1011000};
        bus.instr_i = 32'h010000EF;
        bus.mem_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp += 3;
            if (en !== ee[i]) begin n_bad++; $display("FAIL jal c%0d enables: got %b want %b", i, en, ee[i]); end
            if ((sel & em[i]) !== (es[i] & em[i])) begin n_bad++; $display("FAIL jal c%0d selects: got %b want %b mask %b", i, sel, es[i], em[i]); end
            if (bus.ImmSrc_o !== 2'b11) begin n_bad++; $display("FAIL jal c%0d ImmSrc: got %b want 11", i, bus.ImmSrc_o); end
            @(posedge clk); #1;
        end
        bus.instr_i = 32'h0000007F;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp += 2;
            if (en !== ee2[i]) begin n_bad++; $display("FAIL illegal c%0d enables: got %b want %b", i, en, ee2[i]); end
            if ((sel & M_DP) !== (((i == 1) ? S_DECODE : S_FETCH) & M_DP)) begin n_bad++; $display("FAIL illegal c%0d selects: got %b", i, sel); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.instr_i = 32'h0;
        bus.zero_i = 1'b0;
        bus.mem_ready_i = 1'b1;
        test_reset();
        test_reset_mid_exec();
        test_lw();
        test_add_sub();
        test_beq();
        test_sw_wait();
        test_jal_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
